// File: rtl/avg_thresh_logger_if.sv
// Bus between the sample-average logger and its ROMs / readback logic.
// slave is the logger's view, master is the driving side.
interface avg_thresh_logger_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BUF_W  = 4
);
    logic                    start;
    logic [1:0]              mode;
    logic [ADDR_W-1:0]       sample_addr;
    logic [N_CH*WIDTH-1:0]   sample_data;
    logic [BUF_W-1:0]        rd_addr;
    logic [WIDTH-1:0]        rd_data;
    logic [WIDTH-1:0]        avg_out;
    logic [BUF_W:0]          count;
    logic                    busy;
    logic                    done;
    logic                    ovf;

    modport slave (
        input  start, mode, sample_data, rd_addr,
        output sample_addr, rd_data, avg_out, count, busy, done, ovf
    );

    modport master (
        output start, mode, sample_data, rd_addr,
        input  sample_addr, rd_data, avg_out, count, busy, done, ovf
    );
endinterface

// File: rtl/avg_thresh_logger.sv
// Sweeps the sample ROM address space, averages N_CH channels with round-half-up,
// and logs averages that pass the mode/threshold compare into a small buffer.
module avg_thresh_logger #(
    parameter int unsigned      N_CH   = 2,
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      ADDR_W = 4,
    parameter int unsigned      BUF_W  = 4,
    parameter logic [WIDTH-1:0] THRESH = WIDTH'(15)
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    avg_thresh_logger_if.slave   io_bus
);

    localparam int unsigned LOG_N = $clog2(N_CH);
    localparam int unsigned SUM_W = WIDTH + LOG_N;
    localparam int unsigned DEPTH = 2 ** BUF_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [BUF_W:0]     r_count;
    logic [BUF_W:0]     w_count_next;
    logic               r_ovf;
    logic               w_ovf_next;
    logic               w_wr_en;
    logic               w_qualify;
    logic               w_full;
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_rounded;
    logic [WIDTH-1:0]   w_avg;
    logic [WIDTH-1:0]   r_buf [DEPTH];
    logic [WIDTH-1:0]   r_rd_data;

    // Sum is wide enough for N_CH full-scale samples, so no channel can wrap.
    always_comb begin
        w_sum = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            w_sum = w_sum + SUM_W'(io_bus.sample_data[c*WIDTH +: WIDTH]);
        end
    end

    // Adding N_CH/2 cannot carry out of SUM_W: max is N_CH*2**WIDTH - N_CH/2.
    assign w_rounded = w_sum + SUM_W'(N_CH / 2);
    assign w_avg     = WIDTH'(w_rounded >> LOG_N);

    always_comb begin
        w_qualify = 1'b0;
        case (io_bus.mode)
            2'b00:   w_qualify = (w_avg > THRESH);
            2'b01:   w_qualify = (w_avg < THRESH);
            2'b10:   w_qualify = 1'b1;
            default: w_qualify = 1'b0;
        endcase
    end

    // count only ever reaches exactly DEPTH, so its top bit alone means full.
    assign w_full = r_count[BUF_W];

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        w_wr_en      = 1'b0;

        case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_state_next = StRun;
                    w_addr_next  = '0;
                    w_count_next = '0;
                    w_ovf_next   = 1'b0;
                end
            end
            StRun: begin
                w_addr_next = r_addr + 1'b1;
                if (w_qualify) begin
                    if (w_full) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_count_next = r_count + 1'b1;
                    end
                end
                if (r_addr == '1) begin
                    w_state_next = StDone;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Log storage is deliberately not reset so results survive a clear.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_clr) begin
            r_buf[r_count[BUF_W-1:0]] <= w_avg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[io_bus.rd_addr];
        end
    end

    assign io_bus.sample_addr = r_addr;
    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.avg_out     = w_avg;
    assign io_bus.count       = r_count;
    assign io_bus.busy        = (r_state == StRun);
    assign io_bus.done        = (r_state == StDone);
    assign io_bus.ovf         = r_ovf;

endmodule

// File: tb/tb_avg_thresh_logger.sv
// Self-checking bench for avg_thresh_logger: directed and randomized sweeps
// compared against a queue-based reference model of the logging rules.
module tb_avg_thresh_logger;

    logic clk;
    logic clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rom_a [16][2];
    logic [7:0] rom_b [32][2];

    int exp_q[$];
    int prev_q[$];
    bit exp_ovf;

    avg_thresh_logger_if #(.N_CH(2), .WIDTH(8), .ADDR_W(4), .BUF_W(4)) bus_a ();
    avg_thresh_logger_if #(.N_CH(2), .WIDTH(8), .ADDR_W(5), .BUF_W(4)) bus_b ();

    assign bus_a.sample_data = {rom_a[bus_a.sample_addr][1], rom_a[bus_a.sample_addr][0]};
    assign bus_b.sample_data = {rom_b[bus_b.sample_addr][1], rom_b[bus_b.sample_addr][0]};

    avg_thresh_logger #(.N_CH(2), .WIDTH(8), .ADDR_W(4), .BUF_W(4), .THRESH(8'd15)) u_dut_a (
        .i_clk  (clk),
        .i_clr  (clr),
        .io_bus (bus_a.slave)
    );

    avg_thresh_logger #(.N_CH(2), .WIDTH(8), .ADDR_W(5), .BUF_W(4), .THRESH(8'd15)) u_dut_b (
        .i_clk  (clk),
        .i_clr  (clr),
        .io_bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each sample's rounded mean, filtered by mode, capped at 16 entries.
    function automatic void model(input bit use_b, input logic [1:0] m);
        int ns;
        int a;
        int b;
        int avg;
        bit q;
        ns = use_b ? 32 : 16;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < ns; i++) begin
            a   = use_b ? int'(rom_b[i][0]) : int'(rom_a[i][0]);
            b   = use_b ? int'(rom_b[i][1]) : int'(rom_a[i][1]);
            avg = (a + b + 1) / 2;
            q   = (m == 2'd0) ? (avg > 15) : (m == 2'd1) ? (avg < 15) : (m == 2'd2);
            if (q) begin
                if (exp_q.size() < 16) exp_q.push_back(avg);
                else exp_ovf = 1'b1;
            end
        end
    endfunction

    task automatic fill_a(input int lo, input int hi);
        for (int i = 0; i < 16; i++) begin
            rom_a[i][0] = 8'($urandom_range(hi, lo));
            rom_a[i][1] = 8'($urandom_range(hi, lo));
        end
    endtask

    task automatic sweep_a(input logic [1:0] m, input bit rbw_en, input int old0);
        int n;
        n = 0;
        model(1'b0, m);
        bus_a.mode  = m;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        while (bus_a.busy === 1'b1 && n < 100) begin
            chk("sweep_addr", 32'(bus_a.sample_addr), n);
            if (rbw_en && n == 1) chk("rd_before_write", 32'(bus_a.rd_data), old0);
            n++;
            @(posedge clk); #1;
        end
        chk("busy_len", n, 16);
        chk("done", 32'(bus_a.done), 1);
        chk("count", 32'(bus_a.count), exp_q.size());
        chk("ovf", 32'(bus_a.ovf), 32'(exp_ovf));
        for (int i = 0; i < exp_q.size(); i++) begin
            bus_a.rd_addr = 4'(i);
            @(posedge clk); #1;
            chk("readback", 32'(bus_a.rd_data), exp_q[i]);
        end
    endtask

    initial begin
        int n;
        clr = 1'b1;
        bus_a.start = 1'b0; bus_a.mode = 2'd0; bus_a.rd_addr = '0;
        bus_b.start = 1'b0; bus_b.mode = 2'd0; bus_b.rd_addr = '0;
        for (int i = 0; i < 16; i++) begin rom_a[i][0] = 8'd0; rom_a[i][1] = 8'd0; end
        for (int i = 0; i < 32; i++) begin rom_b[i][0] = 8'd0; rom_b[i][1] = 8'd0; end

        // Reset
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(bus_a.busy), 0);
        chk("rst_done", 32'(bus_a.done), 0);
        chk("rst_count", 32'(bus_a.count), 0);
        chk("rst_ovf", 32'(bus_a.ovf), 0);
        chk("rst_addr", 32'(bus_a.sample_addr), 0);
        chk("rst_rd_data", 32'(bus_a.rd_data), 0);
        chk("rst_b_count", 32'(bus_b.count), 0);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 32'(bus_a.busy), 0);
        chk("idle_done", 32'(bus_a.done), 0);

        // Single qualifying sample at address 3: (10+21+1)/2 = 16
        rom_a[3][0] = 8'd10; rom_a[3][1] = 8'd21;
        sweep_a(2'd0, 1'b0, 0);
        chk("dir_count", 32'(bus_a.count), 1);
        bus_a.rd_addr = 4'd0;
        @(posedge clk); #1;
        chk("dir_rd0", 32'(bus_a.rd_data), 16);

        // Threshold boundaries
        rom_a[3][0] = 8'd0; rom_a[3][1] = 8'd0;
        rom_a[0][0] = 8'd15; rom_a[0][1] = 8'd15;
        rom_a[1][0] = 8'd15; rom_a[1][1] = 8'd16;
        sweep_a(2'd0, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin rom_a[i][0] = 8'd20; rom_a[i][1] = 8'd20; end
        rom_a[0][0] = 8'd14; rom_a[0][1] = 8'd15;
        rom_a[1][0] = 8'd14; rom_a[1][1] = 8'd14;
        sweep_a(2'd1, 1'b0, 0);

        // Width / rounding on the combinational average (sample_addr is 0 in DONE)
        rom_a[0][0] = 8'd200; rom_a[0][1] = 8'd255; #1;
        chk("avg_200_255", 32'(bus_a.avg_out), 228);
        rom_a[0][0] = 8'd255; rom_a[0][1] = 8'd255; #1;
        chk("avg_255_255", 32'(bus_a.avg_out), 255);
        rom_a[0][0] = 8'd0; rom_a[0][1] = 8'd1; #1;
        chk("avg_round_up", 32'(bus_a.avg_out), 1);

        // Randomized sweeps across all modes, values clustered near the threshold
        for (int r = 0; r < 8; r++) begin
            if (r[0]) fill_a(0, 255);
            else fill_a(10, 20);
            sweep_a(2'(r % 4), 1'b0, 0);
        end

        // Fill the whole buffer, then restart from DONE in store-none mode
        fill_a(0, 255);
        sweep_a(2'd2, 1'b0, 0);
        prev_q = exp_q;
        fill_a(0, 255);
        sweep_a(2'd3, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            bus_a.rd_addr = 4'(i);
            @(posedge clk); #1;
            chk("kept_after_restart", 32'(bus_a.rd_data), prev_q[i]);
        end

        // Read and write of entry 0 in the same cycle returns the old value
        fill_a(0, 255);
        rom_a[0][0] = 8'(prev_q[0]) ^ 8'h80;
        rom_a[0][1] = 8'(prev_q[0]) ^ 8'h80;
        bus_a.rd_addr = 4'd0;
        sweep_a(2'd2, 1'b1, prev_q[0]);

        // Clear in the middle of a sweep
        fill_a(0, 255);
        bus_a.mode  = 2'd2;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_addr", 32'(bus_a.sample_addr), 7);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_busy", 32'(bus_a.busy), 0);
        chk("clr_done", 32'(bus_a.done), 0);
        chk("clr_count", 32'(bus_a.count), 0);
        chk("clr_addr", 32'(bus_a.sample_addr), 0);
        @(posedge clk); #1;
        chk("clr_stays_idle", 32'(bus_a.busy), 0);
        sweep_a(2'd2, 1'b0, 0);

        // Overflow: 32 samples, all stored until the 16-entry buffer fills
        for (int i = 0; i < 32; i++) begin
            rom_b[i][0] = 8'($urandom_range(255, 0));
            rom_b[i][1] = 8'($urandom_range(255, 0));
        end
        model(1'b1, 2'd2);
        bus_b.mode  = 2'd2;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        n = 0;
        while (bus_b.busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk("ovf_busy_len", n, 32);
        chk("ovf_count", 32'(bus_b.count), 16);
        chk("ovf_flag", 32'(bus_b.ovf), 1);
        chk("ovf_done", 32'(bus_b.done), 1);
        for (int i = 0; i < 16; i++) begin
            bus_b.rd_addr = 4'(i);
            @(posedge clk); #1;
            chk("ovf_readback", 32'(bus_b.rd_data), exp_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_thresh_logger.md
Name: avg_thresh_logger

Overview:
- Parametrised successor to the two-ROM average/compare/store datapath. Sweeps a sample address space once per start, averages N_CH channel samples with round-half-up, and compares the average against a threshold in one of three modes.
- Qualifying averages are logged into an internal buffer with an occupancy count and an overflow flag.
- Sits between the sample ROMs (combinational read) and the display/readback logic, replacing the ad-hoc counter+FSM cluster.

Parameters:
- N_CH, 2, channel count; power of 2, range 2..8.
- WIDTH, 8, bits per sample and per stored average.
- ADDR_W, 4, sample address width; one sweep = 2**ADDR_W samples.
- BUF_W, 4, log buffer address width; capacity 2**BUF_W entries.
- THRESH, 15, compare threshold (WIDTH bits, unsigned).

Ports:
- clk  in  1  system clock (divided clock at top level); all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  level; sampled each clk; begins a sweep from IDLE or DONE.
- mode  in  2  00 store if avg>THRESH; 01 store if avg<THRESH; 10 store all; 11 store none (sweep only).
- sample_addr  out  ADDR_W  address to all channel ROMs.
- sample_data  in  N_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]; valid in the same cycle as sample_addr.
- rd_addr  in  BUF_W  log readback address.
- rd_data  out  WIDTH  log entry at rd_addr, registered.
- avg_out  out  WIDTH  combinational average of the current sample_data.
- count  out  BUF_W+1  number of entries stored this sweep (0..2**BUF_W).
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- ovf  out  1  a qualifying average was dropped because the buffer was full.

Behaviour:
- Arithmetic: sum = unsigned sum of all N_CH samples at width WIDTH+log2(N_CH), no truncation.
  - avg = (sum + N_CH/2) >> log2(N_CH); the result always fits in WIDTH bits.
  - Example: 255+255 gives 255; it does not wrap.
- Compare: unsigned; modes as listed. In mode 00, avg==THRESH does not qualify; in mode 01 it does not qualify either.
- FSM states:
  - IDLE -> RUN on start=1. On entry: sample_addr<=0, count<=0, ovf<=0.
  - RUN: one sample per cycle. If the current avg qualifies and count<2**BUF_W, then buf[count]<=avg and count<=count+1. If it qualifies and count==2**BUF_W, then ovf<=1 and buf/count are unchanged.
  - RUN address step: sample_addr<=sample_addr+1. When sample_addr==2**ADDR_W-1 (last sample processed), go to DONE. sample_addr then wraps to 0.
  - DONE: done=1; count, ovf and buffer hold. start=1 re-enters RUN with the same entry actions as IDLE->RUN.
- RUN lasts exactly 2**ADDR_W cycles. start is ignored while in RUN. mode is sampled every RUN cycle; changes take effect the next sample.
- Write latency: the sample at address k is written at the end of the k-th RUN cycle. rd_data <= buf[rd_addr] at every edge in every state (1-cycle latency).
- Same-cycle write and read of one address: rd_data returns the old contents (read-before-write).
- Reset (clr=1 at an edge), including mid-sweep:
  - state=IDLE, sample_addr=0, count=0, ovf=0, busy=0, done=0, rd_data=0.
  - Buffer contents are not cleared.
  - clr has priority over start.
- busy/done are registered state decodes; both are never high together.

Test Plan:
- Reset: clr=1 for 2 cycles, then start=0 -> state IDLE, count=0, busy=0, done=0, ovf=0, sample_addr=0, rd_data=0.
- N_CH=2, mode=00, ch0=10 & ch1=21 at addr 3, all other addrs 0/0.
  - start pulse -> busy high for 16 cycles, then done=1, count=1.
  - rd_addr=0 -> rd_data=16 one cycle later.
- Threshold boundary, mode=00:
  - samples 15/15 (avg 15) -> not stored.
  - samples 15/16 (sum 31, avg 16) -> stored.
  - mode=01 with 14/15 (avg 15) -> not stored; 14/14 (avg 14) -> stored.
- Width: ch0=200, ch1=255 -> avg_out=228 (no 8-bit wrap). ch0=ch1=255 -> 255.
- Overflow: mode=10, ADDR_W=5, BUF_W=4 -> 32 qualifying samples; count=16, ovf=1, buf holds samples 0..15 only.
- clr asserted at sweep cycle 7 -> next cycle IDLE, count=0, busy=0. A new start gives a full 16-cycle sweep from addr 0.
- Restart from DONE, mode=11 -> count=0, ovf=0, done after 16 cycles; previous buffer contents still readable.
